// File: rtl/regfile_writeback_if.sv
// Bus bundle between decode/ALU/load unit (master) and the writeback block (slave).
// Forwarding signals exist only when WB_BYPASS_EN is defined.
interface regfile_writeback_if #(
  parameter int PTR_W = 2
);
  logic             alu_valid;
  logic [4:0]       alu_rd;
  logic [31:0]      alu_data;
  logic             alu_ready;
  logic             mem_req_valid;
  logic [4:0]       mem_req_rd;
  logic             mem_req_ready;
  logic             mem_resp_valid;
  logic [31:0]      mem_resp_data;
  logic [4:0]       rs1_q;
  logic [4:0]       rs2_q;
  logic             rs1_busy;
  logic             rs2_busy;
  logic             wb_we;
  logic [4:0]       wb_rd;
  logic [31:0]      wb_wd;
  logic [PTR_W:0]   pend_count;
  logic             err_resp;
`ifdef WB_BYPASS_EN
  logic             fwd1_hit;
  logic             fwd2_hit;
  logic [31:0]      fwd1_data;
  logic [31:0]      fwd2_data;
`endif

  modport master (
    output alu_valid, alu_rd, alu_data, mem_req_valid, mem_req_rd,
           mem_resp_valid, mem_resp_data, rs1_q, rs2_q,
`ifdef WB_BYPASS_EN
    input  fwd1_hit, fwd2_hit, fwd1_data, fwd2_data,
`endif
    input  alu_ready, mem_req_ready, rs1_busy, rs2_busy,
           wb_we, wb_rd, wb_wd, pend_count, err_resp
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, mem_req_valid, mem_req_rd,
           mem_resp_valid, mem_resp_data, rs1_q, rs2_q,
`ifdef WB_BYPASS_EN
    output fwd1_hit, fwd2_hit, fwd1_data, fwd2_data,
`endif
    output alu_ready, mem_req_ready, rs1_busy, rs2_busy,
           wb_we, wb_rd, wb_wd, pend_count, err_resp
  );
endinterface

// File: rtl/regfile_writeback.sv
// Register-file write port arbiter: in-order load writeback (priority) and ALU results,
// with a pending-load queue and busy scoreboard. WB_BYPASS_EN adds writeback forwarding.
module regfile_writeback #(
  parameter int PEND_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input  logic               clk,
  input  logic               rst,
  regfile_writeback_if.slave bus
);
  logic [4:0]       pend_mem [PEND_DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic [PTR_W:0]   count_next;
  logic [31:0]      busy_reg;
  logic [31:0]      busy_next;
  logic             wb_we_reg;
  logic [4:0]       wb_rd_reg;
  logic [31:0]      wb_wd_reg;
  logic             err_reg;

  logic             full;
  logic             resp_pop;
  logic             req_ready;
  logic             req_accept;
  logic             alu_ready;
  logic             alu_accept;
  logic [4:0]       head_rd;

  assign full       = (count_reg == (PTR_W+1)'(PEND_DEPTH));
  assign head_rd    = pend_mem[rd_ptr_reg];
  assign resp_pop   = bus.mem_resp_valid && (count_reg != '0);
  // Ready looks only at registered state, so a same-cycle pop never frees a full queue.
  assign req_ready  = !full && !busy_reg[bus.mem_req_rd];
  assign req_accept = bus.mem_req_valid && req_ready;
  assign alu_ready  = !resp_pop && !((bus.alu_rd != 5'd0) && busy_reg[bus.alu_rd]);
  assign alu_accept = bus.alu_valid && alu_ready;

  always_comb begin
    count_next = count_reg;
    if (req_accept && !resp_pop) count_next = count_reg + 1'b1;
    else if (!req_accept && resp_pop) count_next = count_reg - 1'b1;
  end

  // A busy rd is never re-reserved, so set and clear cannot collide on one bit.
  assign busy_next[0] = 1'b0;
  for (genvar gi = 1; gi < 32; gi++) begin : g_busy
    assign busy_next[gi] = (req_accept && (bus.mem_req_rd == 5'(gi))) ||
                           (busy_reg[gi] && !(resp_pop && (head_rd == 5'(gi))));
  end

  always_ff @(posedge clk) begin
    if (req_accept) pend_mem[wr_ptr_reg] <= bus.mem_req_rd;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      busy_reg   <= '0;
      wb_we_reg  <= 1'b0;
      wb_rd_reg  <= 5'd0;
      wb_wd_reg  <= 32'd0;
      err_reg    <= 1'b0;
    end else begin
      if (req_accept) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (resp_pop)   rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
      busy_reg  <= busy_next;
      if (bus.mem_resp_valid && (count_reg == '0)) err_reg <= 1'b1;

      if (resp_pop) begin
        wb_we_reg <= (head_rd != 5'd0);
        wb_rd_reg <= head_rd;
        wb_wd_reg <= bus.mem_resp_data;
      end else if (alu_accept) begin
        wb_we_reg <= (bus.alu_rd != 5'd0);
        wb_rd_reg <= bus.alu_rd;
        wb_wd_reg <= bus.alu_data;
      end else begin
        wb_we_reg <= 1'b0;
      end
    end
  end

  assign bus.alu_ready     = alu_ready;
  assign bus.mem_req_ready = req_ready;
  assign bus.rs1_busy      = busy_reg[bus.rs1_q];
  assign bus.rs2_busy      = busy_reg[bus.rs2_q];
  assign bus.wb_we         = wb_we_reg;
  assign bus.wb_rd         = wb_rd_reg;
  assign bus.wb_wd         = wb_wd_reg;
  assign bus.pend_count    = count_reg;
  assign bus.err_resp      = err_reg;

`ifdef WB_BYPASS_EN
  assign bus.fwd1_hit  = wb_we_reg && (wb_rd_reg == bus.rs1_q) && (bus.rs1_q != 5'd0);
  assign bus.fwd2_hit  = wb_we_reg && (wb_rd_reg == bus.rs2_q) && (bus.rs2_q != 5'd0);
  assign bus.fwd1_data = wb_wd_reg;
  assign bus.fwd2_data = wb_wd_reg;
`endif
endmodule

// File: tb/tb_regfile_writeback.sv
// Scenario bench for regfile_writeback; register writes are checked against an expected-write queue.
module tb_regfile_writeback;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] wd;
  } wr_t;
  wr_t exp_q[$];

  regfile_writeback_if #(.PTR_W(2)) bus ();

  regfile_writeback #(.PEND_DEPTH(4), .PTR_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  // Every register-file write must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (mon_en && !rst && (bus.wb_we === 1'b1)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wb_unexpected: got write rd=%0d wd=%h, required no write", bus.wb_rd, bus.wb_wd);
      end else begin
        e = exp_q.pop_front();
        if (bus.wb_rd !== e.rd || bus.wb_wd !== e.wd) begin
          n_fail++;
          $display("FAIL wb_write: got rd=%0d wd=%h, required rd=%0d wd=%h", bus.wb_rd, bus.wb_wd, e.rd, e.wd);
        end else begin
          $display("write rd=%0d wd=%h ok", bus.wb_rd, bus.wb_wd);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_valid      = 1'b0;
    bus.alu_rd         = 5'd0;
    bus.alu_data       = 32'd0;
    bus.mem_req_valid  = 1'b0;
    bus.mem_req_rd     = 5'd0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = 32'd0;
  endtask

  task automatic test_reset();
    idle();
    bus.rs1_q = 5'd0;
    bus.rs2_q = 5'd0;
    #12 rst = 1'b0;
    tick();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hA5A5A5A5;
    bus.mem_req_valid = 1'b1; bus.mem_req_rd = 5'd3;
    tick();
    idle();
    n_checks++;
    if (bus.wb_we !== 1'b1 || bus.pend_count !== 3'd1) begin
      n_fail++;
      $display("FAIL pre_reset: got wb_we=%b pend=%0d, required wb_we=1 pend=1", bus.wb_we, bus.pend_count);
    end
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if (bus.wb_we !== 1'b0 || bus.wb_rd !== 5'd0 || bus.wb_wd !== 32'd0 ||
        bus.pend_count !== 3'd0 || bus.err_resp !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got we=%b rd=%0d wd=%h pend=%0d err=%b, required all 0",
               bus.wb_we, bus.wb_rd, bus.wb_wd, bus.pend_count, bus.err_resp);
    end
    for (int q = 0; q < 32; q++) begin
      bus.rs1_q = 5'(q);
      #1;
      n_checks++;
      if (bus.rs1_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_busy: rs1_q=%0d got busy=%b, required 0", q, bus.rs1_busy);
      end
    end
    bus.rs1_q = 5'd0;
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    $display("reset test done");
  endtask

  task automatic test_alu();
    tick();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    #1;
    n_checks++;
    if (bus.alu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL alu_ready_rd5: got %b, required 1", bus.alu_ready);
    end
    exp_q.push_back('{rd: 5'd5, wd: 32'hDEADBEEF});
    tick();
    n_checks++;
    if (bus.wb_we !== 1'b1 || bus.wb_rd !== 5'd5 || bus.wb_wd !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL alu_latency: got we=%b rd=%0d wd=%h, required 1/5/deadbeef", bus.wb_we, bus.wb_rd, bus.wb_wd);
    end
    bus.alu_rd = 5'd0; bus.alu_data = 32'h00001234;
    #1;
    n_checks++;
    if (bus.alu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL alu_ready_rd0: got %b, required 1", bus.alu_ready);
    end
    tick();
    idle();
    n_checks++;
    if (bus.wb_we !== 1'b0 || bus.wb_rd !== 5'd0) begin
      n_fail++;
      $display("FAIL alu_x0: got we=%b rd=%0d, required we=0 rd=0", bus.wb_we, bus.wb_rd);
    end
  endtask

  task automatic test_load_order();
    logic [4:0]  rds [3];
    logic [31:0] dat [3];
    rds = '{5'd3, 5'd7, 5'd9};
    dat = '{32'h11, 32'h22, 32'h33};
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.mem_req_valid = 1'b1; bus.mem_req_rd = rds[i];
      #1;
      n_checks++;
      if (bus.mem_req_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL load_req_ready: rd=%0d got %b, required 1", rds[i], bus.mem_req_ready);
      end
    end
    tick();
    idle();
    bus.rs1_q = 5'd7;
    #1;
    n_checks++;
    if (bus.pend_count !== 3'd3 || bus.rs1_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL load_reserve: got pend=%0d busy7=%b, required pend=3 busy7=1", bus.pend_count, bus.rs1_busy);
    end
    for (int i = 0; i < 3; i++) begin
      bus.mem_resp_valid = 1'b1; bus.mem_resp_data = dat[i];
      exp_q.push_back('{rd: rds[i], wd: dat[i]});
      tick();
      n_checks++;
      if (bus.wb_we !== 1'b1 || bus.wb_rd !== rds[i]) begin
        n_fail++;
        $display("FAIL load_consecutive: step %0d got we=%b rd=%0d, required we=1 rd=%0d", i, bus.wb_we, bus.wb_rd, rds[i]);
      end
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      bus.rs1_q = rds[i];
      #1;
      n_checks++;
      if (bus.rs1_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL load_busy_clear: rd=%0d got %b, required 0", rds[i], bus.rs1_busy);
      end
    end
    n_checks++;
    if (bus.pend_count !== 3'd0) begin
      n_fail++;
      $display("FAIL load_drain: got pend=%0d, required 0", bus.pend_count);
    end
    bus.rs1_q = 5'd0;
  endtask

  task automatic test_full_priority();
    for (int i = 1; i <= 4; i++) begin
      tick();
      bus.mem_req_valid = 1'b1; bus.mem_req_rd = 5'(i);
    end
    tick();
    bus.mem_req_rd = 5'd5;
    #1;
    n_checks++;
    if (bus.mem_req_ready !== 1'b0 || bus.pend_count !== 3'd4) begin
      n_fail++;
      $display("FAIL full: got ready=%b pend=%0d, required ready=0 pend=4", bus.mem_req_ready, bus.pend_count);
    end
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'hA1;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd12; bus.alu_data = 32'h00C0FFEE;
    #1;
    n_checks++;
    if (bus.mem_req_ready !== 1'b0 || bus.alu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL priority: got req_ready=%b alu_ready=%b, required 0/0", bus.mem_req_ready, bus.alu_ready);
    end
    exp_q.push_back('{rd: 5'd1, wd: 32'hA1});
    tick();
    bus.mem_req_valid = 1'b0; bus.mem_resp_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.alu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL alu_after_load: got alu_ready=%b, required 1", bus.alu_ready);
    end
    exp_q.push_back('{rd: 5'd12, wd: 32'h00C0FFEE});
    tick();
    bus.alu_valid = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'hB0 + 32'(i);
      exp_q.push_back('{rd: 5'(i), wd: 32'hB0 + 32'(i)});
      tick();
    end
    idle();
    bus.mem_req_valid = 1'b1; bus.mem_req_rd = 5'd3;
    #1;
    n_checks++;
    if (bus.mem_req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL dup_first: got ready=%b, required 1", bus.mem_req_ready);
    end
    tick();
    #1;
    n_checks++;
    if (bus.mem_req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL dup_second: got ready=%b, required 0", bus.mem_req_ready);
    end
    tick();
    bus.mem_req_rd = 5'd9;
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'hC3;
    exp_q.push_back('{rd: 5'd3, wd: 32'hC3});
    tick();
    bus.mem_req_valid = 1'b0;
    n_checks++;
    if (bus.pend_count !== 3'd1) begin
      n_fail++;
      $display("FAIL push_pop_count: got pend=%0d, required 1", bus.pend_count);
    end
    bus.mem_resp_data = 32'hC9;
    exp_q.push_back('{rd: 5'd9, wd: 32'hC9});
    tick();
    idle();
    tick();
  endtask

  task automatic test_waw_error();
    bus.mem_req_valid = 1'b1; bus.mem_req_rd = 5'd4;
    tick();
    bus.mem_req_valid = 1'b0;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'h44;
    #1;
    n_checks++;
    if (bus.alu_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL waw_stall: got alu_ready=%b, required 0", bus.alu_ready);
    end
    tick();
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'h400;
    exp_q.push_back('{rd: 5'd4, wd: 32'h400});
    tick();
    bus.mem_resp_valid = 1'b0;
    #1;
    n_checks++;
    if (bus.alu_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL waw_release: got alu_ready=%b, required 1", bus.alu_ready);
    end
    exp_q.push_back('{rd: 5'd4, wd: 32'h44});
    tick();
    idle();
    tick();
    n_checks++;
    if (bus.pend_count !== 3'd0 || bus.err_resp !== 1'b0) begin
      n_fail++;
      $display("FAIL waw_end: got pend=%0d err=%b, required 0/0", bus.pend_count, bus.err_resp);
    end
    bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 32'hBAD;
    tick();
    idle();
    n_checks++;
    if (bus.err_resp !== 1'b1 || bus.wb_we !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_resp: got err=%b we=%b, required err=1 we=0", bus.err_resp, bus.wb_we);
    end
    tick();
    n_checks++;
    if (bus.err_resp !== 1'b1) begin
      n_fail++;
      $display("FAIL err_sticky: got %b, required 1", bus.err_resp);
    end
  endtask

  task automatic test_bypass();
`ifdef WB_BYPASS_EN
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd6; bus.alu_data = 32'h55;
    bus.rs1_q = 5'd6; bus.rs2_q = 5'd6;
    exp_q.push_back('{rd: 5'd6, wd: 32'h55});
    tick();
    idle();
    n_checks++;
    if (bus.fwd2_hit !== 1'b1 || bus.fwd2_data !== 32'h55 || bus.fwd1_hit !== 1'b1) begin
      n_fail++;
      $display("FAIL fwd_hit: got fwd1=%b fwd2=%b data=%h, required 1/1/55", bus.fwd1_hit, bus.fwd2_hit, bus.fwd2_data);
    end
    bus.rs2_q = 5'd0;
    #1;
    n_checks++;
    if (bus.fwd2_hit !== 1'b0) begin
      n_fail++;
      $display("FAIL fwd_x0: got fwd2_hit=%b, required 0", bus.fwd2_hit);
    end
    bus.rs1_q = 5'd0;
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_order();
    test_full_priority();
    test_waw_error();
    test_bypass();
    tick();
    tick();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d writes outstanding, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Writer-side companion to the 32x32 register file. Drives its write port (we/rd/wd) from two result sources: single-cycle ALU results, and in-order responses from a multi-cycle load unit.
- Holds a small queue of outstanding load destinations and a per-register busy scoreboard.
- The decode stage uses the busy bits to stall on RAW/WAW hazards.

Parameters:
- PEND_DEPTH, 4, max outstanding loads (power of 2, >=2).
- PTR_W, 2, log2(PEND_DEPTH); queue pointer width.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- alu_valid  input  1  ALU result present
- alu_rd  input  5  ALU destination
- alu_data  input  32  ALU result
- alu_ready  output  1  ALU result accepted this cycle (combinational)
- mem_req_valid  input  1  load issued, destination to reserve
- mem_req_rd  input  5  load destination
- mem_req_ready  output  1  reservation accepted (combinational)
- mem_resp_valid  input  1  load data returning (in issue order)
- mem_resp_data  input  32  load data
- rs1_q, rs2_q  input  5 each  hazard query addresses
- rs1_busy, rs2_busy  output  1 each  queried reg has pending load (combinational)
- wb_we  output  1  register-file write enable (registered)
- wb_rd  output  5  register-file write address (registered)
- wb_wd  output  32  register-file write data (registered)
- pend_count  output  PTR_W+1  outstanding loads
- err_resp  output  1  sticky: response arrived with empty queue

Behaviour:
- Reset (async, immediate on rst high): wb_we=0, wb_rd=0, wb_wd=0, queue empty, pend_count=0, all busy bits 0, err_resp=0. A reset mid-load discards all pending entries; late responses after reset set err_resp.
- Queue: circular FIFO of PEND_DEPTH 5-bit rds with rd/wr pointers and a count. Full when count==PEND_DEPTH. Pointers wrap modulo PEND_DEPTH.
- Busy vector, 32 bits:
  - bit r set on mem_req accept with r!=0.
  - bit r cleared when the load to r writes back.
  - bit 0 is always 0.
- mem_req_ready = !full && !busy[mem_req_rd].
  - A second load to an already-busy rd is refused until the first completes. There is therefore never a same-cycle set/clear conflict on one bit.
  - Same-cycle response pop does not relieve full; ready depends on registered state only.
- Response handling (mem_resp_valid && count>0): pop head rd. Next edge: wb_we=(head!=0), wb_rd=head, wb_wd=mem_resp_data; clear busy[head].
- mem_resp_valid with count==0: response dropped, err_resp<=1 (cleared only by rst).
- alu_ready = !(mem_resp_valid && count>0) && !(alu_rd!=0 && busy[alu_rd]).
  - Load writeback has priority over ALU.
  - An ALU write to a busy reg stalls (WAW ordering).
- ALU accept (alu_valid && alu_ready): next edge wb_we=(alu_rd!=0), wb_rd=alu_rd, wb_wd=alu_data.
- Neither source writing: wb_we<=0; wb_rd/wb_wd hold.
- Latency: exactly one cycle from accept to the wb_* outputs. Throughput: one write per cycle.
- Simultaneous req accept + resp pop: count unchanged, both pointers advance.
- rs*_busy = busy[rs*_q]; query of x0 always returns 0.

Optional Feature:
- Macro WB_BYPASS_EN.
- Defined: adds outputs fwd1_hit, fwd2_hit (1 bit) and fwd1_data, fwd2_data (32 bits).
  - fwdN_hit = wb_we && wb_rd==rsN_q && rsN_q!=0.
  - fwdN_data = wb_wd.
  - Lets decode see the value being written this cycle, before the register file updates.
- Undefined: ports absent; decode must wait one extra cycle after writeback.

Test Plan:
- Reset state: assert rst mid-cycle -> all outputs 0 immediately; pend_count=0, rs1_busy=0 for every address.
- ALU path: alu_valid, rd=5, data=0xDEADBEEF -> alu_ready=1; next cycle wb_we=1, wb_rd=5, wb_wd=0xDEADBEEF. Repeat with rd=0 -> wb_we=0.
- Load order: reserve rd=3, 7, 9 (pend_count=3, rs1_q=7 -> busy=1). Three responses 0x11, 0x22, 0x33 -> writes (3,0x11), (7,0x22), (9,0x33) on consecutive cycles; busy bits clear; pend_count=0.
- Full/priority: reserve 4 loads -> mem_req_ready=0. Same cycle resp + alu_valid (rd=12) -> alu_ready=0, load written first; ALU written the next cycle. Reserve rd=3 twice -> second refused.
- WAW/error: load pending on rd=4, alu_rd=4 -> alu_ready=0 until load writes back. mem_resp_valid with empty queue -> err_resp=1, no write.
- Bypass (WB_BYPASS_EN): wb write rd=6 value 0x55, rs2_q=6 -> fwd2_hit=1, fwd2_data=0x55. rs2_q=0 -> fwd2_hit=0.
